// File: rtl/jk_cmd_sequencer.sv
// Command-driven J/K stimulus stage: holds a J/K pattern for len cycles, tracks the
// expected flip-flop state and checks the returned Q once the command completes.
module jk_cmd_sequencer #(
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             J,
    output logic             K,
    input  logic             q_in,
    output logic             q_exp,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic               j_nxt, k_nxt, q_exp_nxt, busy_nxt, done_nxt, err_nxt, ready_nxt;
    logic [ERR_W-1:0]   err_count_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            J         <= 1'b0;
            K         <= 1'b0;
            q_exp     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            J         <= j_nxt;
            K         <= k_nxt;
            q_exp     <= q_exp_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            cmd_ready <= ready_nxt;
            err_count <= err_count_nxt;
        end
    end

    // The latched op lives in J/K themselves; they are held constant through DRIVE.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        j_nxt         = J;
        k_nxt         = K;
        q_exp_nxt     = q_exp;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        ready_nxt     = cmd_ready;
        err_count_nxt = err_count;
        case (state)
            IDLE: begin
                j_nxt     = 1'b0;
                k_nxt     = 1'b0;
                ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    j_nxt     = cmd_op[1];
                    k_nxt     = cmd_op[0];
                    cnt_nxt   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                case ({J, K})
                    2'b01:   q_exp_nxt = 1'b0;
                    2'b10:   q_exp_nxt = 1'b1;
                    2'b11:   q_exp_nxt = ~q_exp;
                    default: q_exp_nxt = q_exp;
                endcase
                cnt_nxt = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    j_nxt     = 1'b0;
                    k_nxt     = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                done_nxt = 1'b1;
                if (q_in != q_exp) begin
                    err_nxt = 1'b1;
                    if (err_count != '1)
                        err_count_nxt = err_count + ERR_W'(1);
                end
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: a real JK flip-flop closes the loop on q_in and a
// command-level model predicts q_exp, err and the saturating err_count.
module tb_jk_cmd_sequencer;

    localparam int LEN_W = 4;
    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             J, K, q_in, q_exp, busy, done, err;
    logic [ERR_W-1:0] err_count;

    logic q_ff;
    logic fault = 1'b0;
    logic fault_val = 1'b0;

    int total = 0;
    int bad = 0;
    logic mdl_q = 1'b0;
    int   mdl_err = 0;

    jk_cmd_sequencer #(.LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .J(J), .K(K), .q_in(q_in),
        .q_exp(q_exp), .busy(busy), .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) q_ff <= 1'b0;
        else case ({J, K})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    assign q_in = fault ? fault_val : q_ff;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Net effect of holding an op for n cycles on a flip-flop at q.
    function automatic logic apply_op(input logic q, input logic [1:0] op, input int n);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return q ^ n[0];
            default: return q;
        endcase
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input bit hold);
        int leff;
        logic exp_err;
        wait_ready();
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        leff = (len == 0) ? 1 : int'(len);
        for (int i = 0; i < leff; i++) begin
            check("drv_jk", 32'({J, K}), 32'(op));
            check("drv_busy", 32'(busy), 1);
            check("drv_ready", 32'(cmd_ready), 0);
            check("drv_done", 32'(done), 0);
            @(negedge clk);
        end
        check("chk_jk", 32'({J, K}), 0);
        check("chk_busy", 32'(busy), 1);
        check("chk_done", 32'(done), 0);
        mdl_q   = apply_op(mdl_q, op, leff);
        exp_err = fault && (fault_val != mdl_q);
        if (exp_err && mdl_err < (1 << ERR_W) - 1) mdl_err++;
        @(negedge clk);
        check("done", 32'(done), 1);
        check("err", 32'(err), 32'(exp_err));
        check("q_exp", 32'(q_exp), 32'(mdl_q));
        check("err_count", 32'(err_count), 32'(mdl_err));
        check("end_busy", 32'(busy), 0);
        check("end_ready", 32'(cmd_ready), 1);
        check("end_jk", 32'({J, K}), 0);
    endtask

    task automatic check_idle_after_done();
        @(negedge clk);
        check("done_clear", 32'(done), 0);
        check("err_clear", 32'(err), 0);
    endtask

    initial begin
        // reset and idle
        repeat (2) begin
            @(negedge clk);
            check("rst_out", 32'({J, K, cmd_ready, busy, done, err, q_exp}), 0);
            check("rst_errcnt", 32'(err_count), 0);
        end
        #1 rst = 1'b1;
        #1 check("ready_before_edge", 32'(cmd_ready), 0);
        @(negedge clk);
        check("ready_after_edge", 32'(cmd_ready), 1);
        check("idle_jk", 32'({J, K}), 0);

        // set then toggle
        do_cmd(2'b10, 4'd1, 1'b0);
        do_cmd(2'b11, 4'd3, 1'b0);
        check_idle_after_done();

        // reset op then hold
        do_cmd(2'b01, 4'd2, 1'b0);
        do_cmd(2'b00, 4'd5, 1'b0);

        // back-to-back zero-length toggles with cmd_valid held
        for (int i = 0; i < 3; i++) do_cmd(2'b11, 4'd0, 1'b1);
        cmd_valid = 1'b0;
        check_idle_after_done();

        // maximum length
        do_cmd(2'b11, 4'd15, 1'b0);

        // fault injection up to saturation
        fault = 1'b1;
        fault_val = 1'b1;
        for (int i = 0; i < 4; i++) do_cmd(2'b01, 4'd1, 1'b0);
        check("err_sat", 32'(err_count), 3);
        fault = 1'b0;

        // reset in the middle of a drive
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = 4'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_out", 32'({J, K, busy, q_exp, done, cmd_ready}), 0);
        check("midrst_errcnt", 32'(err_count), 0);
        mdl_q = 1'b0;
        mdl_err = 0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_nodone", 32'(done), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(cmd_ready), 1);
        do_cmd(2'b10, 4'd1, 1'b0);
        do_cmd(2'b11, 4'd3, 1'b0);

        // randomized commands with occasional faults
        for (int n = 0; n < 40; n++) begin
            fault     = ($urandom_range(0, 5) == 0);
            fault_val = 1'($urandom_range(0, 1));
            do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            cmd_valid = 1'b0;
            fault = 1'b0;
        end
        check_idle_after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its J/K inputs. It accepts {op, len} commands over a valid/ready handshake and holds the matching J/K pattern for len clock cycles. It keeps an internal model of the flip-flop state, checks the returned Q against that model, and reports done, error and a saturating error count.

Parameters:
LEN_W, 4, width of cmd_len. Maximum drive length is 2^LEN_W-1 cycles.
ERR_W, 8, width of the saturating err_count.

Ports:
clk  input  1  rising-edge clock shared with the flip-flop
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 hold, 01 reset (J0K1), 10 set (J1K0), 11 toggle (J1K1)
cmd_len  input  LEN_W  number of drive cycles; 0 is treated as 1
J  output  1  to flip-flop J
K  output  1  to flip-flop K
q_in  input  1  flip-flop Q
q_exp  output  1  model value of Q
busy  output  1  high in DRIVE or CHECK
done  output  1  one-cycle pulse at end of command
err  output  1  one-cycle pulse, coincident with done, on mismatch
err_count  output  ERR_W  saturating mismatch count

Behaviour:
- Reset (rst=0, async, immediate):
  - State goes to IDLE.
  - J=K=0, cmd_ready=0, busy=0, done=0, err=0, q_exp=0, err_count=0, internal counter=0.
  - Clock-independent. Legal mid-command: any drive in progress is abandoned with no done pulse.
- All outputs are registered.
- cmd_ready rises at the first rising edge after rst deasserts.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - cmd_ready=1, J=K=0.
  - A command is accepted at an edge E0 where cmd_valid & cmd_ready.
  - At E0: latch op; load counter with max(cmd_len,1); set J/K per op; cmd_ready<=0, busy<=1; go to DRIVE.
  - cmd_valid while cmd_ready=0 is ignored; the source must hold it until accepted.
- DRIVE:
  - J/K stay constant. At each edge, q_exp is updated by the JK rule: 00 keep, 01 clear, 10 set, 11 invert.
  - Counter decrements at each edge.
  - On the edge where the counter reaches 0 (edge E_len, len edges after E0): J<=0, K<=0, go to CHECK.
  - The flip-flop therefore samples the op on exactly len edges, E1..E_len.
- CHECK (one cycle):
  - At edge E_len+1: compare q_in with q_exp.
  - done<=1. err<=1 on mismatch, and err_count increments, saturating at 2^ERR_W-1.
  - busy<=0, cmd_ready<=1, go to IDLE.
- done/err deassert at the next edge.
- Latency: accept to done-high is len+1 cycles. The earliest next accept is at edge E_len+2.
- The model q_exp is never resynchronised from q_in. A mismatch persists in later checks until reset.
- Boundary cases:
  - cmd_len=0 behaves exactly as cmd_len=1.
  - cmd_len=2^LEN_W-1 needs no counter wrap.
  - err_count stays at its maximum when saturated.
  - A new command presented in the done cycle is not accepted until that cycle ends, because the accept is registered on the following edge.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release -> all outputs 0 during reset; cmd_ready=1 one edge after release; J=K=0.
2. Set then toggle: {10,len=1} then {11,len=3}, with a real JK flip-flop on q_in -> J=1,K=0 for 1 cycle, done after 2 cycles, q_exp=1, err=0; toggle gives J=K=1 for 3 cycles, q_exp=0, done/err=0, err_count=0.
3. Reset op and hold: {01,len=2} then {00,len=5} -> q_exp=0 both times; J/K=01 for exactly 2 cycles, then 00; done 6 cycles after the second accept.
4. Fault injection: q_in tied to 1, issue {01,len=1} three times -> err pulses with each done; err_count=3. With ERR_W=2 and 4 failures, err_count saturates at 3.
5. Handshake and zero length: cmd_valid held with {11,len=0} across back-to-back commands -> accepts are 3 cycles apart; J/K asserted 1 cycle each; cmd_ready low between accepts.
6. Reset mid-drive: {11,len=10}, pull rst low after 4 cycles -> J=K=0, busy=0 and q_exp=0 immediately; no done pulse; the next command after release behaves as in scenario 2.
